// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_gen_if
// Pixel request bus between the raster timing engine and the pixel source.
//   data_req    : pixel_xpos/pixel_ypos carry a valid request this cycle
//   pixel_xpos  : requested column
//   pixel_ypos  : requested row
//   pixel_data  : RGB565 word returned by the source at fixed latency
// master = timing engine (issues requests), slave = pixel source.
// ---------------------------------------------------------------------------
interface video_timing_gen_if;
   logic        data_req;
   logic [11:0] pixel_xpos;
   logic [11:0] pixel_ypos;
   logic [15:0] pixel_data;

   modport master (
      output data_req,
      output pixel_xpos,
      output pixel_ypos,
      input  pixel_data
   );

   modport slave (
      input  data_req,
      input  pixel_xpos,
      input  pixel_ypos,
      output pixel_data
   );
endinterface

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Raster timing engine for the HDMI output path. Walks a horizontal and a
// vertical counter over the full frame, asks the pixel source for each
// active pixel early enough to hide its read latency, expands the returned
// RGB565 word to RGB888 and presents registered sync/de/rgb to the encoder.
//
// Ports:
//   pixel_clk   : pixel clock, all logic on its rising edge
//   rst         : asynchronous active-high reset
//   pix         : request bus (data_req, pixel_xpos, pixel_ypos out,
//                 pixel_data in)
//   video_hs    : horizontal sync, active level SYNC_POL
//   video_vs    : vertical sync, active level SYNC_POL
//   video_de    : display enable
//   video_rgb   : RGB888 pixel, zero outside the active area
//   frame_start : one-cycle pulse on the first output cycle of a frame
// ---------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int H_DISP   = 1280,
   parameter int H_FRONT  = 110,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter int V_DISP   = 720,
   parameter int V_FRONT  = 5,
   parameter int SYNC_POL = 1,
   parameter int DATA_LAT = 1
) (
   input  logic               pixel_clk,
   input  logic               rst,
   video_timing_gen_if.master pix,
   output logic               video_hs,
   output logic               video_vs,
   output logic               video_de,
   output logic [23:0]        video_rgb,
   output logic               frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int H_ACT_S = H_SYNC + H_BACK;
   localparam int H_ACT_E = H_ACT_S + H_DISP;
   localparam int V_ACT_S = V_SYNC + V_BACK;
   localparam int V_ACT_E = V_ACT_S + V_DISP;

   localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_SYNC_E  = 12'(H_SYNC);
   localparam logic [11:0] V_SYNC_E  = 12'(V_SYNC);
   localparam logic [11:0] H_ACT_S_C = 12'(H_ACT_S);
   localparam logic [11:0] H_ACT_E_C = 12'(H_ACT_E);
   localparam logic [11:0] V_ACT_S_C = 12'(V_ACT_S);
   localparam logic [11:0] V_ACT_E_C = 12'(V_ACT_E);
   localparam logic [11:0] REQ_S     = 12'(H_ACT_S - DATA_LAT);
   localparam logic [11:0] REQ_E     = 12'(H_ACT_E - DATA_LAT);
   localparam logic        ACT_LVL   = (SYNC_POL != 0);

   // Illegal parameter sets are rejected at elaboration: the request window
   // has to fit inside the blanking that precedes the active area, and the
   // 12-bit counters must hold the whole raster.
   if (DATA_LAT < 0 || DATA_LAT > 3) begin : gBadLatRange
      $error("video_timing_gen: DATA_LAT must be in 0..3");
   end
   if (H_ACT_S < DATA_LAT) begin : gBadLatFit
      $error("video_timing_gen: H_SYNC+H_BACK must be >= DATA_LAT");
   end
   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : gBadTotal
      $error("video_timing_gen: raster does not fit 12-bit counters");
   end

   logic [11:0] hCnt_q, hCnt_d;
   logic [11:0] vCnt_q, vCnt_d;
   logic        vActive;
   logic        deInt;
   logic        reqInt;
   logic [23:0] rgbExp;
   logic        hs_q, vs_q, de_q, frameStart_q;
   logic [23:0] rgb_q;

   // Next raster position: the line counter advances only when the pixel
   // counter wraps, and the frame wraps on the last pixel of the last line.
   always_comb begin
      hCnt_d = hCnt_q + 12'd1;
      vCnt_d = vCnt_q;
      if (hCnt_q == H_LAST) begin
         hCnt_d = '0;
         vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 12'd1;
      end
   end

   // Raster counters. Reset parks them at (0,0) so the first frame after
   // release begins cleanly regardless of where the previous one stopped.
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
      end
   end

   // Region decode. The request window is the active window shifted left by
   // the source latency, so the word for column x lands exactly when the
   // internal enable reaches column x. Because the shift is to the left it
   // can never spill into the following line. Requests are held off while
   // reset is asserted.
   always_comb begin
      vActive = (vCnt_q >= V_ACT_S_C) && (vCnt_q < V_ACT_E_C);
      deInt   = (hCnt_q >= H_ACT_S_C) && (hCnt_q < H_ACT_E_C) && vActive;
      reqInt  = (hCnt_q >= REQ_S) && (hCnt_q < REQ_E) && vActive && !rst;
      pix.data_req   = reqInt;
      pix.pixel_xpos = reqInt ? (hCnt_q - REQ_S) : '0;
      pix.pixel_ypos = reqInt ? (vCnt_q - V_ACT_S_C) : '0;
   end

   // RGB565 to RGB888 by replicating each channel's top bits into the new
   // low bits, so full-scale maps to 0xFF and zero stays zero.
   always_comb begin
      rgbExp = {pix.pixel_data[15:11], pix.pixel_data[15:13],
                pix.pixel_data[10:5],  pix.pixel_data[10:9],
                pix.pixel_data[4:0],   pix.pixel_data[4:2]};
   end

   // Single output register stage: every video output reflects the counter
   // state of the previous cycle. Pixel data is only captured while the
   // internal enable is high, so whatever the source drives during blanking
   // never reaches the encoder.
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         hs_q         <= ~ACT_LVL;
         vs_q         <= ~ACT_LVL;
         de_q         <= 1'b0;
         rgb_q        <= '0;
         frameStart_q <= 1'b0;
      end else begin
         hs_q         <= (hCnt_q < H_SYNC_E) ? ACT_LVL : ~ACT_LVL;
         vs_q         <= (vCnt_q < V_SYNC_E) ? ACT_LVL : ~ACT_LVL;
         de_q         <= deInt;
         rgb_q        <= deInt ? rgbExp : 24'h000000;
         frameStart_q <= (hCnt_q == '0) && (vCnt_q == '0);
      end
   end

   assign video_hs    = hs_q;
   assign video_vs    = vs_q;
   assign video_de    = de_q;
   assign video_rgb   = rgb_q;
   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Directed bench for video_timing_gen. Instance A uses a tiny 15x7 raster
// with a one-cycle registered pixel source; instance B uses the 720p
// defaults with a combinational source and inverted sync polarity.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

   logic pixel_clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;

   // Free-running pixel clock, period 10.
   always #5 pixel_clk = ~pixel_clk;

   video_timing_gen_if pixA ();
   video_timing_gen_if pixB ();

   logic        hsA, vsA, deA, fsA;
   logic [23:0] rgbA;
   logic        hsB, vsB, deB, fsB;
   logic [23:0] rgbB;

   video_timing_gen #(
      .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
      .SYNC_POL(1), .DATA_LAT(1)
   ) dutA (
      .pixel_clk   (pixel_clk),
      .rst         (rstA),
      .pix         (pixA),
      .video_hs    (hsA),
      .video_vs    (vsA),
      .video_de    (deA),
      .video_rgb   (rgbA),
      .frame_start (fsA)
   );

   video_timing_gen #(
      .SYNC_POL(0), .DATA_LAT(0)
   ) dutB (
      .pixel_clk   (pixel_clk),
      .rst         (rstB),
      .pix         (pixB),
      .video_hs    (hsB),
      .video_vs    (vsB),
      .video_de    (deB),
      .video_rgb   (rgbB),
      .frame_start (fsB)
   );

   // Pixel source for A: one-cycle registered read. Mode 0 returns a word
   // encoding the requested (x,y); mode 1 returns a fixed colour per column.
   // With no request it returns 0xFFFF as blanking garbage.
   int          srcMode = 0;
   logic [15:0] srcWordA = 16'hFFFF;
   logic [15:0] patTab [4] = '{16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};

   always @(posedge pixel_clk) begin
      if (pixA.data_req) begin
         if (srcMode == 0)
            srcWordA <= {pixA.pixel_ypos[4:0], pixA.pixel_xpos[5:0], 5'h00};
         else
            srcWordA <= patTab[pixA.pixel_xpos[1:0]];
      end else begin
         srcWordA <= 16'hFFFF;
      end
   end

   assign pixA.pixel_data = srcWordA;

   // Combinational source for B: pure red while requested.
   assign pixB.pixel_data = pixB.data_req ? 16'hF800 : 16'h0000;

   int checkCount = 0;
   int passCount  = 0;

   // Capture buffers for A. Entry n is sampled on the falling edge after
   // rising edge n: requests there reflect raster index n, registered video
   // outputs reflect raster index n-1.
   logic        reqArr [0:255];
   logic [11:0] xArr   [0:255];
   logic [11:0] yArr   [0:255];
   logic        hsArr  [0:255];
   logic        vsArr  [0:255];
   logic        deArr  [0:255];
   logic        fsArr  [0:255];
   logic [23:0] rgbArr [0:255];

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic recordReq(input int n);
      reqArr[n] = pixA.data_req;
      xArr[n]   = pixA.pixel_xpos;
      yArr[n]   = pixA.pixel_ypos;
   endtask

   task automatic resetA();
      rstA = 1'b1;
      repeat (3) @(negedge pixel_clk);
      rstA = 1'b0;
      recordReq(0);
   endtask

   task automatic applyStimulus(input int nCycles);
      for (int n = 1; n <= nCycles; n++) begin
         @(posedge pixel_clk);
         @(negedge pixel_clk);
         recordReq(n);
         hsArr[n]  = hsA;
         vsArr[n]  = vsA;
         deArr[n]  = deA;
         fsArr[n]  = fsA;
         rgbArr[n] = rgbA;
      end
   endtask

   logic [23:0] expTab [4] = '{24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};

   initial begin
      int hsCnt, vsCnt, deCnt, fsCnt, reqCnt, badRgb, firstReq, firstDe, maxX;
      int i, h, v, x, y;
      logic [23:0] expRgb;

      // ---- Reset state of A -------------------------------------------
      @(negedge pixel_clk);
      checkOutput("rst_hs", hsA, 0);
      checkOutput("rst_vs", vsA, 0);
      checkOutput("rst_de", deA, 0);
      checkOutput("rst_rgb", rgbA, 0);
      checkOutput("rst_fs", fsA, 0);
      checkOutput("rst_req", pixA.data_req, 0);

      // ---- Scenarios 1-3: two free-running frames, (x,y) source ----------
      srcMode = 0;
      resetA();
      applyStimulus(210);
      hsCnt = 0; vsCnt = 0; deCnt = 0; fsCnt = 0; badRgb = 0;
      for (int n = 1; n <= 210; n++) begin
         hsCnt += int'(hsArr[n]);
         vsCnt += int'(vsArr[n]);
         deCnt += int'(deArr[n]);
         fsCnt += int'(fsArr[n]);
         if (!deArr[n] && rgbArr[n] != 24'h0) badRgb++;
      end
      checkOutput("s1_hs_high", hsCnt, 28);
      checkOutput("s1_vs_high", vsCnt, 30);
      checkOutput("s1_de_high", deCnt, 64);
      checkOutput("s1_fs_count", fsCnt, 2);
      checkOutput("s1_fs_first", fsArr[1], 1);
      checkOutput("s1_fs_second", fsArr[106], 1);
      checkOutput("s1_vs_last_hi", vsArr[15], 1);
      checkOutput("s1_vs_first_lo", vsArr[16], 0);
      checkOutput("s1_hs_edge", {31'd0, hsArr[2]} * 2 + {31'd0, hsArr[3]}, 2);

      firstReq = -1; firstDe = -1; reqCnt = 0; maxX = 0;
      for (int n = 0; n <= 104; n++) begin
         if (reqArr[n]) begin
            reqCnt++;
            if (firstReq < 0) firstReq = n;
            if (int'(xArr[n]) > maxX) maxX = int'(xArr[n]);
         end
      end
      for (int n = 1; n <= 104; n++)
         if (deArr[n] && firstDe < 0) firstDe = n;
      checkOutput("s2_first_req", firstReq, 34);
      checkOutput("s2_first_x", xArr[34], 0);
      checkOutput("s2_first_y", yArr[34], 0);
      checkOutput("s2_last_req", reqArr[41], 1);
      checkOutput("s2_last_x", xArr[41], 7);
      checkOutput("s2_after_last", reqArr[42], 0);
      checkOutput("s2_last_line_y", yArr[79], 3);
      checkOutput("s2_req_count", reqCnt, 32);
      checkOutput("s2_max_x", maxX, 7);
      checkOutput("s2_de_lag", firstDe - firstReq, 2);

      for (int n = 1; n <= 210; n++) begin
         if (deArr[n]) begin
            i = n - 1;
            h = i % 15;
            v = (i / 15) % 7;
            x = h - 5;
            y = v - 2;
            expRgb = {y[4:0], 3'b000, x[5:0], 2'b00, 8'h00};
            checkOutput($sformatf("s3_rgb_x%0d_y%0d", x, y), rgbArr[n], expRgb);
         end
      end
      checkOutput("s3_blank_rgb", badRgb, 0);

      // ---- Scenario 4: colour table, 0xFFFF garbage in blanking -----------
      srcMode = 1;
      resetA();
      applyStimulus(105);
      badRgb = 0;
      for (int n = 1; n <= 105; n++) begin
         if (deArr[n]) begin
            x = ((n - 1) % 15) - 5;
            checkOutput($sformatf("s4_rgb_x%0d", x), rgbArr[n], expTab[x % 4]);
         end else if (rgbArr[n] != 24'h0) begin
            badRgb++;
         end
      end
      checkOutput("s4_blank_rgb", badRgb, 0);

      // ---- Scenario 5: asynchronous reset mid active line -----------------
      srcMode = 0;
      resetA();
      applyStimulus(53);
      checkOutput("s5_pre_de", deA, 1);
      checkOutput("s5_pre_req", pixA.data_req, 1);
      #1 rstA = 1'b1;
      #1;
      checkOutput("s5_async_hs", hsA, 0);
      checkOutput("s5_async_vs", vsA, 0);
      checkOutput("s5_async_de", deA, 0);
      checkOutput("s5_async_rgb", rgbA, 0);
      checkOutput("s5_async_fs", fsA, 0);
      checkOutput("s5_async_req", pixA.data_req, 0);
      checkOutput("s5_async_x", pixA.pixel_xpos, 0);
      checkOutput("s5_async_y", pixA.pixel_ypos, 0);
      @(posedge pixel_clk);
      #1;
      checkOutput("s5_hold_hs", hsA, 0);
      checkOutput("s5_hold_fs", fsA, 0);
      repeat (2) @(posedge pixel_clk);
      @(negedge pixel_clk);
      rstA = 1'b0;
      recordReq(0);
      applyStimulus(106);
      fsCnt = 0;
      for (int n = 1; n <= 106; n++) fsCnt += int'(fsArr[n]);
      checkOutput("s5_fs_first", fsArr[1], 1);
      checkOutput("s5_fs_next", fsArr[106], 1);
      checkOutput("s5_fs_count", fsCnt, 2);
      checkOutput("s5_hs_after", hsArr[1], 1);
      checkOutput("s5_vs_after", vsArr[1], 1);

      // ---- Scenario 6: 720p defaults, DATA_LAT=0, active-low sync ---------
      begin
         logic prevHs, prevVs;
         int hsFall0, hsFall1, hsLow, vsRise, reqRise, deRise, lastReq;
         int reqX0, reqY0, maxXB, maxYB, fsCntB;
         logic [23:0] rgbFirst;
         prevHs = 1'b1; prevVs = 1'b1;
         hsFall0 = -1; hsFall1 = -1; hsLow = 0; vsRise = -1; reqRise = -1;
         deRise = -1; lastReq = -1; reqX0 = -1; reqY0 = -1; maxXB = 0;
         maxYB = 0; fsCntB = 0; rgbFirst = '0;
         rstB = 1'b1;
         @(negedge pixel_clk);
         checkOutput("s6_rst_hs", hsB, 1);
         checkOutput("s6_rst_vs", vsB, 1);
         rstB = 1'b0;
         for (int n = 1; n <= 42800; n++) begin
            @(posedge pixel_clk);
            @(negedge pixel_clk);
            if (n == 1) begin
               checkOutput("s6_first_hs", hsB, 0);
               checkOutput("s6_first_vs", vsB, 0);
               checkOutput("s6_first_fs", fsB, 1);
            end
            if (prevHs && !hsB) begin
               if (hsFall0 < 0) hsFall0 = n;
               else if (hsFall1 < 0) hsFall1 = n;
            end
            if (n <= 1650 && !hsB) hsLow++;
            if (!prevVs && vsB && vsRise < 0) vsRise = n;
            if (pixB.data_req) begin
               if (reqRise < 0) begin
                  reqRise = n;
                  reqX0 = int'(pixB.pixel_xpos);
                  reqY0 = int'(pixB.pixel_ypos);
               end
               lastReq = n;
               if (int'(pixB.pixel_xpos) > maxXB) maxXB = int'(pixB.pixel_xpos);
               if (int'(pixB.pixel_ypos) > maxYB) maxYB = int'(pixB.pixel_ypos);
            end
            if (deB && deRise < 0) begin
               deRise = n;
               rgbFirst = rgbB;
            end
            fsCntB += int'(fsB);
            prevHs = hsB;
            prevVs = vsB;
         end
         checkOutput("s6_hs_fall0", hsFall0, 1);
         checkOutput("s6_hs_period", hsFall1 - hsFall0, 1650);
         checkOutput("s6_hs_low", hsLow, 40);
         checkOutput("s6_vs_rise", vsRise, 8251);
         checkOutput("s6_req_rise", reqRise, 41510);
         checkOutput("s6_req_x0", reqX0, 0);
         checkOutput("s6_req_y0", reqY0, 0);
         checkOutput("s6_de_lag", deRise - reqRise, 1);
         checkOutput("s6_rgb_first", rgbFirst, 24'hFF0000);
         checkOutput("s6_last_req", lastReq, 42789);
         checkOutput("s6_max_x", maxXB, 1279);
         checkOutput("s6_max_y", maxYB, 0);
         checkOutput("s6_fs_count", fsCntB, 1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-clock-domain raster timing engine for the PPU HDMI output path.
- Sits directly upstream of the pixel-data generator: drives pixel_xpos/pixel_ypos and a data request early enough to cover the source's read latency.
- Takes the returned RGB565 word, expands it to RGB888 and emits registered hsync/vsync/de/rgb to the TMDS encoder.

Parameters:
- H_SYNC, 40: horizontal sync width, pixels.
- H_BACK, 220: horizontal back porch.
- H_DISP, 1280: active pixels per line.
- H_FRONT, 110: horizontal front porch.
- V_SYNC, 5: vertical sync width, lines.
- V_BACK, 20: vertical back porch.
- V_DISP, 720: active lines.
- V_FRONT, 5: vertical front porch.
- SYNC_POL, 1: sync active level (1 = active-high).
- DATA_LAT, 1: pixel source read latency, cycles; legal range 0..3.

Ports:
- pixel_clk  input  1  pixel clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pixel_xpos  output  12  requested pixel column, 0..H_DISP-1.
- pixel_ypos  output  12  requested pixel row, 0..V_DISP-1.
- data_req  output  1  pixel_xpos/pixel_ypos valid this cycle.
- pixel_data  input  16  RGB565 {R5,G6,B5}; valid DATA_LAT cycles after the matching data_req.
- video_hs  output  1  horizontal sync.
- video_vs  output  1  vertical sync.
- video_de  output  1  display enable.
- video_rgb  output  24  RGB888 {R8,G8,B8}.
- frame_start  output  1  one-cycle pulse marking the first cycle of each frame.

Behaviour:
- Counters:
  - H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL likewise.
  - h_cnt (12b) counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt (12b) increments when h_cnt wraps, and wraps to 0 when it is V_TOTAL-1 at that point.
- Region order within a line and within a frame: sync, back porch, active, front porch.
  - H_ACT_S = H_SYNC+H_BACK; H_ACT_E = H_ACT_S+H_DISP (exclusive).
  - V_ACT_S and V_ACT_E are defined the same way.
- Internal de = (H_ACT_S <= h_cnt < H_ACT_E) && (V_ACT_S <= v_cnt < V_ACT_E).
- Request window, decoded from the registered counters:
  - data_req = 1 when H_ACT_S-DATA_LAT <= h_cnt < H_ACT_E-DATA_LAT and v_cnt is in the active lines.
  - pixel_xpos = h_cnt-(H_ACT_S-DATA_LAT) while data_req is 1, else 0.
  - pixel_ypos = v_cnt-V_ACT_S while data_req is 1, else 0.
  - The request for column x therefore precedes internal de for column x by exactly DATA_LAT cycles.
- Consume: pixel_data is sampled on the cycle internal de is 1. DATA_LAT=0 means a combinational source.
- Output stage: one register stage. Outputs change one cycle after the counter state they reflect.
  - video_hs = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
  - video_vs = SYNC_POL when v_cnt < V_SYNC, else ~SYNC_POL. It switches on the h_cnt=0 boundary.
  - video_de = internal de.
  - video_rgb = expand(pixel_data) when internal de is 1, else 24'h000000.
  - frame_start = 1 for the cycle after h_cnt=0 and v_cnt=0.
- Expansion rule (MSB replication):
  - R8 = {R5, R5[4:2]}.
  - G8 = {G6, G6[5:4]}.
  - B8 = {B5, B5[4:2]}.
- Reset (asynchronous, immediate):
  - h_cnt = v_cnt = 0.
  - video_hs = video_vs = ~SYNC_POL; video_de = 0; video_rgb = 0; frame_start = 0.
  - data_req = 0; pixel_xpos = pixel_ypos = 0.
  - After release, counting starts at h_cnt = 0 on the first clock edge.
  - Reset mid-frame discards the partial frame; the next frame starts from (0,0) with frame_start asserted.
- Boundaries:
  - Last active pixel of the last active line: de drops at H_ACT_E; no request is issued for any column >= H_DISP.
  - The request window never crosses into the next line.
  - H_ACT_S must be >= DATA_LAT; this is a parameter legality rule checked by an elaboration-time assertion.
- No back-pressure: the source must return data at fixed latency. Stale or garbage pixel_data outside de never reaches video_rgb.

Test Plan:
- Setup for scenarios 1-5: H=2/3/8/2 (H_TOTAL 15), V=1/1/4/1 (V_TOTAL 7), DATA_LAT=1, SYNC_POL=1.
- 1. Reset then free-run 2 frames -> video_hs high for 2 of every 15 cycles; video_vs high for exactly 15 cycles per 105-cycle frame; frame_start pulses every 105 cycles; video_de high 8 cycles on each of 4 lines.
- 2. Monitor the request window -> data_req first rises at h_cnt=4 with pixel_xpos=0 and ends at h_cnt=11 with xpos=7; ypos runs 0..3; video_de rises exactly 2 cycles after data_req rises.
- 3. Model a 1-cycle registered source returning {ypos[4:0], xpos[5:0], 5'h00} -> every active video_rgb equals the expansion of the expected (x,y) word; no off-by-one at column 0 or column 7.
- 4. Drive 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000 during de -> video_rgb = 00FF00, 0000FF, FFFFFF, 000000; pixel_data forced to FFFF outside de -> video_rgb stays 000000.
- 5. Assert rst mid-active line 2 for 3 cycles -> all outputs go to reset values asynchronously; after release the first frame_start occurs 1 cycle after the first edge and a full 105-cycle frame follows.
- 6. DATA_LAT=0, SYNC_POL=0 -> data_req coincides with internal de; sync outputs idle high and pulse low; 1280x720 defaults give H_TOTAL 1650 and V_TOTAL 750 over one frame.
